// File: rtl/gate_bist_pkg.sv
// Shared types and reference truth tables for the gate BIST controller.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Bit k is the expected output for input vector k (a = MSB, b = LSB).
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;

endpackage

// File: rtl/bist_settle_counter.sv
// Loadable settle down-counter; zero flags the final wait cycle of a vector dwell.
module bist_settle_counter #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(SETTLE - 1);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_bist.sv
// Exhaustive-sweep BIST for a small combinational gate: drive, settle, sample,
// compare against TRUTH, and report error count and first failing vector.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter logic [2**N_IN-1:0]    TRUTH  = OR_TT,
  parameter int                    SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_valid
);

  state_t          state, state_next;
  logic [N_IN-1:0] idx;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            mismatch, last;
  logic [N_IN:0]   err_next;

  bist_settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  assign mismatch = (dut_out != TRUTH[idx]);
  assign last     = (idx == {N_IN{1'b1}});
  assign err_next = err_count + (N_IN+1)'(mismatch);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_SETTLE;
          cnt_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (last) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          cnt_load   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // pass is computed from err_next so it reflects the last vector's result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx              <= '0;
      err_count        <= '0;
      first_fail       <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx              <= '0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail       <= idx;
            first_fail_valid <= 1'b1;
          end
          if (last) begin
            idx  <= '0;
            pass <= (err_next == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_in = idx;
  assign busy   = (state == ST_SETTLE) || (state == ST_SAMPLE);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_gate_bist.sv
// Bench for gate_bist: a 2-input instance with a programmable gate model and a
// 3-input OR instance, both checked against a truth-table scoreboard.
module tb_gate_bist;
  import gate_bist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b;

  logic [1:0] in_a;
  logic       out_a, busy_a, done_a, pass_a, ffv_a;
  logic [2:0] err_a;
  logic [1:0] ff_a;
  logic [3:0] gate_tt;

  logic [2:0] in_b;
  logic       out_b, busy_b, done_b, pass_b, ffv_b;
  logic [3:0] err_b;
  logic [2:0] ff_b;

  assign out_a = gate_tt[in_a];
  assign out_b = |in_b;

  gate_bist #(.N_IN(2), .TRUTH(OR_TT), .SETTLE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_in(in_a), .dut_out(out_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail(ff_a), .first_fail_valid(ffv_a)
  );

  gate_bist #(.N_IN(3), .TRUTH(8'hFE), .SETTLE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_in(in_b), .dut_out(out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail(ff_b), .first_fail_valid(ffv_b)
  );

  int sel;
  logic [31:0] o_in, o_err, o_ff;
  logic        o_busy, o_done, o_pass, o_ffv;

  always_comb begin
    o_in = 32'(in_a); o_err = 32'(err_a); o_ff = 32'(ff_a);
    o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_ffv = ffv_a;
    if (sel != 0) begin
      o_in = 32'(in_b); o_err = 32'(err_b); o_ff = 32'(ff_b);
      o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_ffv = ffv_b;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " dut_in"}, o_in, 0);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " pass"}, 32'(o_pass), 0);
    chk({tag, " err_count"}, o_err, 0);
    chk({tag, " first_fail"}, o_ff, 0);
    chk({tag, " first_fail_valid"}, 32'(o_ffv), 0);
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 0) start_a = v;
    else            start_b = v;
  endtask

  // One full sweep: expectations come from comparing gate table to reference table.
  task automatic run_sweep(input string tag, input int which, input logic [31:0] gate_tbl,
                           input logic [31:0] ref_tt, input bit hold);
    int n, s, nv, dwell, exp_err, exp_ff;
    bit exp_ffv;
    n = (which == 0) ? 2 : 3;
    s = (which == 0) ? 2 : 1;
    nv = 1 << n;
    dwell = s + 1;
    exp_err = 0; exp_ff = 0; exp_ffv = 1'b0;
    for (int k = 0; k < nv; k++) begin
      if (gate_tbl[k] != ref_tt[k]) begin
        exp_err++;
        if (!exp_ffv) begin exp_ff = k; exp_ffv = 1'b1; end
      end
    end
    sel = which;
    @(negedge clk);
    if (which == 0) gate_tt = gate_tbl[3:0];
    set_start(which, 1'b1);
    for (int t = 0; t < nv * dwell; t++) begin
      @(negedge clk);
      if (!hold) set_start(which, 1'b0);
      chk({tag, " dut_in"}, o_in, 32'(t / dwell));
      chk({tag, " busy"}, 32'(o_busy), 1);
      chk({tag, " done"}, 32'(o_done), 0);
      if (t == 0) chk({tag, " err_cleared"}, o_err, 0);
    end
    @(negedge clk);
    set_start(which, 1'b0);
    chk({tag, " done_final"}, 32'(o_done), 1);
    chk({tag, " busy_final"}, 32'(o_busy), 0);
    chk({tag, " dut_in_final"}, o_in, 0);
    chk({tag, " err_count"}, o_err, 32'(exp_err));
    chk({tag, " pass"}, 32'(o_pass), (exp_err == 0) ? 1 : 0);
    chk({tag, " first_fail_valid"}, 32'(o_ffv), 32'(exp_ffv));
    chk({tag, " first_fail"}, o_ff, 32'(exp_ff));
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      chk({tag, " done_held"}, 32'(o_done), 1);
      chk({tag, " err_held"}, o_err, 32'(exp_err));
    end
  endtask

  initial begin
    int stop_t;
    logic [3:0] rnd_tt;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; gate_tt = OR_TT; sel = 0;
    repeat (2) @(negedge clk);
    sel = 0; #1 check_zero("reset_a");
    sel = 1; #1 check_zero("reset_b");
    rst_n = 1'b1;

    run_sweep("or_clean", 0, 32'hE, 32'hE, 1'b0);
    run_sweep("and_wrong", 0, 32'h8, 32'hE, 1'b0);
    run_sweep("stuck1", 0, 32'hF, 32'hE, 1'b0);
    run_sweep("stuck0", 0, 32'h0, 32'hE, 1'b0);
    run_sweep("nor_wrong", 0, 32'h1, 32'hE, 1'b0);

    // Reset somewhere within vector 2's dwell; results must not survive.
    sel = 0; gate_tt = OR_TT;
    stop_t = 6 + $urandom_range(0, 2);
    @(negedge clk);
    start_a = 1'b1;
    for (int t = 0; t <= stop_t; t++) begin
      @(negedge clk);
      start_a = 1'b0;
      chk("midrst dut_in", o_in, 32'(t / 3));
    end
    rst_n = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check_zero("midrst");
    rst_n = 1'b1;
    run_sweep("after_rst", 0, 32'hE, 32'hE, 1'b0);

    run_sweep("hold_start", 0, 32'hE, 32'hE, 1'b1);
    run_sweep("restart", 0, 32'hE, 32'hE, 1'b0);
    run_sweep("wide_or", 1, 32'hFE, 32'hFE, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rnd_tt = 4'($urandom);
      run_sweep("rand_gate", 0, 32'(rnd_tt), 32'hE, ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
# gate_bist

Synthesizable built-in self-test controller for small combinational gates such as the 2-input OR. It drives every input combination onto a gate under test, waits a programmable settle time, samples the gate output and compares it against a parameterized truth table. It then reports pass/fail, the error count and the first failing vector. It replaces simulation-only stimulus-and-monitor checking with a hardware checker that runs the same exhaustive sweep on silicon or FPGA.

## Interface

Parameters:
- `N_IN`, default 2: number of gate inputs, 1..6.
- `TRUTH`, default 4'b1110: expected output, 2**N_IN bits; bit k is the expected `dut_out` for input vector k (OR).
- `SETTLE`, default 2: wait cycles before each sample, minimum 1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a sweep; sampled in IDLE or DONE only.
- `dut_in` out N_IN: registered stimulus to gate; bit N_IN-1 = first operand (`a`), bit 0 = last (`b`).
- `dut_out` in 1: gate output.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep finished; held until next start or reset.
- `pass` out 1: done and zero errors; qualified by `done`.
- `err_count` out N_IN+1: number of mismatching vectors.
- `first_fail` out N_IN: vector index of first mismatch.
- `first_fail_valid` out 1: `first_fail` holds a captured value.

## Operation

- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `start`=1 → load vector index 0 onto `dut_in`.
  - Clear `err_count`, `first_fail`, `first_fail_valid`, `pass`, `done`.
  - Load settle counter with SETTLE-1 and go to SETTLE.
- SETTLE: decrement counter; at 0 → SAMPLE.
- SAMPLE:
  - Compare `dut_out` with TRUTH[index].
  - On mismatch: increment `err_count`. If `first_fail_valid`=0, capture index into `first_fail` and set `first_fail_valid`.
  - If index = 2**N_IN-1 → DONE, with `pass` = (final error count == 0) registered in the same edge.
  - Otherwise increment index, drive it on `dut_in`, reload counter, → SETTLE.
- DONE: `done`=1, results frozen. `start`=1 → same action as from IDLE (restart).
- `start` is ignored in SETTLE/SAMPLE; holding it high does not restart a running sweep.
- `dut_in` returns to 0 on entry to DONE.
- `err_count` cannot overflow: its width covers 2**N_IN errors.

## Timing

- Reset (`rst_n` low at a clock edge) → all outputs 0 after that edge, state IDLE, index and counter 0. This applies from any state, including mid-sweep; no partial results survive.
- Reset has priority over `start` in the same cycle.
- Start accepted at edge E0 → `busy`=1 and `dut_in`=0 after E0.
- Each vector is held for SETTLE+1 cycles. `dut_out` is sampled at the last edge of its dwell, the same edge that loads the next vector.
- Vector k appears after edge E0 + k·(SETTLE+1).
- `done`=1, `busy`=0 and final results appear after edge E0 + 2**N_IN·(SETTLE+1). Default parameters give 12 cycles.
- `busy` and `done` are never high together.
- On restart from DONE, `done` falls after the accepting edge.

## Structure

- Shared package `gate_bist_pkg`:
  - State enum type.
  - Truth-table constants for 2-input gates: OR_TT=4'b1110, AND_TT=4'b1000, XOR_TT=4'b0110, NAND_TT=4'b0111, NOR_TT=4'b0001.
- Sub-module `bist_settle_counter`: loadable down-counter with a `zero` flag, parameterized by SETTLE.
- Everything else stays in `gate_bist`.

## Test plan

- **Clean OR:** `orGate` as DUT, default parameters, 1-cycle start pulse → `dut_in` = 00, 01, 10, 11 for 3 cycles each. `done` after 12 cycles, `pass`=1, `err_count`=0, `first_fail_valid`=0.
- **Wrong gate:** AND gate as DUT with TRUTH=OR_TT → `err_count`=2, `first_fail`=01, `first_fail_valid`=1, `pass`=0.
- **Stuck-at-1 output:** `dut_out` tied to 1 → `err_count`=1, `first_fail`=00, `pass`=0. Stuck-at-0 → `err_count`=3, `first_fail`=01.
- **Mid-sweep reset:** `rst_n` low for one edge while vector 10 is applied → next cycle all outputs 0 and state IDLE. A subsequent start completes a full clean pass in 12 cycles.
- **Start handling:** `start` held high for the entire sweep → exactly one sweep, `done` at cycle 12. Start pulse in DONE → `done` falls, counts cleared, new sweep completes identically.
- **Wider gate:** N_IN=3, SETTLE=1, TRUTH=8'hFE with a 3-input OR → 8 vectors, 16-cycle sweep, `pass`=1.
